rom_data_arbiter: RTL

ROM_DATA_ARBITER -- requirements
Module: rom_data_arbiter

---
 rtl/rom_data_arbiter_if.sv | 46 ++++
 rtl/rom_data_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rom_data_arbiter_if.sv
// rom_data_arbiter_if
// Bundles the two requester ports and the ROM data port of rom_data_arbiter.
//   i_M0_REQ/i_M1_REQ     requester access request, held until its GNT
//   i_M0_ADDR/i_M1_ADDR   requester byte address (32 bits)
//   i_M0_HB/i_M1_HB       access size: 00 byte, 01 halfword, others word
//   o_M0_GNT/o_M1_GNT     one-cycle completion strobe to the owning requester
//   o_M0_RDATA/o_M1_RDATA read data, valid only while the matching GNT is high
//   o_ERR                 timed-out access marker, coincident with a GNT
//   o_ROM_CE/o_ROM_REQ    ROM data-port enable and request
//   o_ROM_ADDR/o_ROM_HB   latched address and size driven to the ROM
//   i_ROM_GNT/i_ROM_RDATA ROM completion strobe and read data
// The arbiter connects through modport master; the requesters and ROM
// side (or a testbench) connect through modport slave.
interface rom_data_arbiter_if;
  logic        i_M0_REQ;
  logic        i_M1_REQ;
  logic [31:0] i_M0_ADDR;
  logic [31:0] i_M1_ADDR;
  logic [1:0]  i_M0_HB;
  logic [1:0]  i_M1_HB;
  logic        o_M0_GNT;
  logic        o_M1_GNT;
  logic [31:0] o_M0_RDATA;
  logic [31:0] o_M1_RDATA;
  logic        o_ERR;
  logic        o_ROM_CE;
  logic        o_ROM_REQ;
  logic [31:0] o_ROM_ADDR;
  logic [1:0]  o_ROM_HB;
  logic        i_ROM_GNT;
  logic [31:0] i_ROM_RDATA;

  modport master (
    input  i_M0_REQ, i_M1_REQ, i_M0_ADDR, i_M1_ADDR, i_M0_HB, i_M1_HB,
    input  i_ROM_GNT, i_ROM_RDATA,
    output o_M0_GNT, o_M1_GNT, o_M0_RDATA, o_M1_RDATA, o_ERR,
    output o_ROM_CE, o_ROM_REQ, o_ROM_ADDR, o_ROM_HB
  );

  modport slave (
    output i_M0_REQ, i_M1_REQ, i_M0_ADDR, i_M1_ADDR, i_M0_HB, i_M1_HB,
    output i_ROM_GNT, i_ROM_RDATA,
    input  o_M0_GNT, o_M1_GNT, o_M0_RDATA, o_M1_RDATA, o_ERR,
    input  o_ROM_CE, o_ROM_REQ, o_ROM_ADDR, o_ROM_HB
  );
endinterface

// File: rtl/rom_data_arbiter.sv
// rom_data_arbiter
// Shares one ROM data port between two requesters (M0, M1) with round-robin
// arbitration and an access timeout.
//   TIMEOUT  BUSY cycles without i_ROM_GNT before the access aborts (2..255)
//   i_CLK    clock, rising edge
//   i_RSTn   asynchronous active-low reset
//   bus      rom_data_arbiter_if.master: requester and ROM signals
// Sequence per access: IDLE (arbitrate, latch ADDR/HB) -> BUSY (drive ROM,
// wait for i_ROM_GNT or timeout, grant combinationally) -> DONE (one cycle
// with ROM REQ low) -> IDLE.
module rom_data_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic             i_CLK,
  input logic             i_RSTn,
  rom_data_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic        owner, owner_nxt;   // 0 = M0, 1 = M1
  logic        last, last_nxt;     // last-served requester
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] addr, addr_nxt;
  logic [1:0]  hb, hb_nxt;

  logic        pick;
  logic        fin;
  logic [31:0] fin_data;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= 8'd0;
      addr  <= 32'd0;
      hb    <= 2'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      addr  <= addr_nxt;
      hb    <= hb_nxt;
    end
  end

  // With both requesting, serve the one that was not served last;
  // with a single request, that requester wins regardless of the pointer.
  assign pick = (bus.i_M0_REQ && bus.i_M1_REQ) ? ~last : bus.i_M1_REQ;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    hb_nxt    = hb;
    fin       = 1'b0;
    fin_data  = 32'd0;

    bus.o_ROM_CE   = 1'b0;
    bus.o_ROM_REQ  = 1'b0;
    bus.o_ROM_ADDR = 32'd0;
    bus.o_ROM_HB   = 2'd0;
    bus.o_ERR      = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.i_M0_REQ || bus.i_M1_REQ) begin
          owner_nxt = pick;
          addr_nxt  = pick ? bus.i_M1_ADDR : bus.i_M0_ADDR;
          hb_nxt    = pick ? bus.i_M1_HB : bus.i_M0_HB;
          cnt_nxt   = 8'd0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus.o_ROM_CE   = 1'b1;
        bus.o_ROM_REQ  = 1'b1;
        bus.o_ROM_ADDR = addr;
        bus.o_ROM_HB   = hb;
        // A ROM answer in the timeout cycle still wins over the error.
        if (bus.i_ROM_GNT) begin
          fin      = 1'b1;
          fin_data = bus.i_ROM_RDATA;
        end else if (cnt == TO_CNT) begin
          fin       = 1'b1;
          bus.o_ERR = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
        if (fin) begin
          last_nxt  = owner;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // ROM REQ low for one cycle lets the ROM re-arm its grant.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    bus.o_M0_GNT   = fin && !owner;
    bus.o_M1_GNT   = fin && owner;
    bus.o_M0_RDATA = (fin && !owner) ? fin_data : 32'd0;
    bus.o_M1_RDATA = (fin && owner) ? fin_data : 32'd0;
  end

endmodule
